uc_es_handshake: RTL and testbench

//   Parametrised I/O stall controller for the control unit; replaces the fixed

---
 rtl/uc_es_handshake_if.sv | 48 ++++
 rtl/uc_es_handshake.sv | 204 ++++++++++++++++++++
 tb/tb_uc_es_handshake.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_es_handshake_if.sv
`default_nettype none
// ============================================================================
//  Module   : uc_es_handshake_if
//  Purpose  : Bundle of the instruction-side and handshake signals exchanged
//             between the control unit and the I/O stall controller.
//  Signals  : instr        - current instruction word
//             swap_SO      - OS context swap active (freezes the controller)
//             ch_btn       - raw asynchronous confirm buttons, 1 = pressed
//             pausaPC      - 1 = PC may advance, 0 = PC stalled
//             controle_in  - instr decodes as IN
//             controle_out - instr decodes as OUT
//             es_ch        - channel being served
//             busy         - handshake in progress
//             es_done      - one-cycle pulse, handshake completed by release
//             es_timeout   - one-cycle pulse, handshake ended by timeout
//             es_err       - one-cycle pulse, request on a non-existent channel
//  Modports : master drives instr/swap_SO/ch_btn, slave is the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface uc_es_handshake_if #(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [31:0]     instr;
    logic            swap_SO;
    logic [N_CH-1:0] ch_btn;
    logic            pausaPC;
    logic            controle_in;
    logic            controle_out;
    logic [CH_W-1:0] es_ch;
    logic            busy;
    logic            es_done;
    logic            es_timeout;
    logic            es_err;

    modport master (
        output instr, swap_SO, ch_btn,
        input  pausaPC, controle_in, controle_out, es_ch, busy,
               es_done, es_timeout, es_err
    );

    modport slave (
        input  instr, swap_SO, ch_btn,
        output pausaPC, controle_in, controle_out, es_ch, busy,
               es_done, es_timeout, es_err
    );
endinterface
`default_nettype wire

// File: rtl/uc_es_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : uc_es_handshake
//  Purpose  : Parametrised I/O stall controller. Decodes IN/OUT instructions
//             and holds the PC until the selected confirm button has been
//             debounced-pressed and released, or an optional timeout expires.
//  Ports    : clk   - system clock, all state on posedge
//             rst_n - asynchronous active-low reset
//             bus   - uc_es_handshake_if.slave (instruction, buttons, stall
//                     control and status pulses)
//  Params   : N_CH        number of confirm channels (1..32)
//             DEB_CYCLES  stable synchronised samples needed to accept a level
//             TIMEOUT_CYC max cycles in the WAIT states, 0 = no timeout
//  Revision : 1.0 - initial release
// ============================================================================
module uc_es_handshake #(
    parameter int N_CH        = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    uc_es_handshake_if.slave bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [5:0]       N_CH_6   = 6'(N_CH);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] S_WAIT_RELEASE = 2'd2;
    localparam logic [1:0] S_DONE         = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [CH_W-1:0] es_ch_q,  es_ch_d;
    logic [DEB_W-1:0] deb_q,   deb_d;
    logic [TO_W-1:0] to_q,     to_d;
    logic [N_CH-1:0] sync1_q,  sync1_d;
    logic [N_CH-1:0] sync2_q,  sync2_d;
    logic            done_q,   done_d;
    logic            tmo_q,    tmo_d;
    logic            err_q,    err_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic            w_op_zero;
    logic [4:0]      w_rs;
    logic [CH_W-1:0] w_sel;
    logic            w_sel_ok;
    logic            w_req;

    assign w_op_zero        = (bus.instr[31:26] == 6'd0);
    assign bus.controle_in  = w_op_zero && (bus.instr[5:0] == 6'd0);
    assign bus.controle_out = w_op_zero && (bus.instr[5:0] == 6'd1);
    assign w_req            = bus.controle_in || bus.controle_out;
    assign w_rs             = bus.instr[25:21];
    assign w_sel            = bus.instr[21 +: CH_W];
    // Range check uses the whole rs field so that an out-of-range channel
    // number is rejected instead of aliasing onto a low channel.
    assign w_sel_ok         = ({1'b0, w_rs} < N_CH_6);

    // ------------------------------------------------------------------
    // Watched button: only the synchronised level of es_ch matters.
    // ------------------------------------------------------------------
    logic w_btn;
    always_comb begin
        w_btn = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (es_ch_q == CH_W'(i)) begin
                w_btn = sync2_q[i];
            end
        end
    end

    // Level being debounced: pressed in WAIT_PRESS, released in WAIT_RELEASE.
    logic w_target;
    logic w_deb_hit;
    logic w_to_hit;

    assign w_target  = (state_q == S_WAIT_PRESS) ? w_btn : ~w_btn;
    assign w_deb_hit = w_target && (deb_q == DEB_LAST);
    assign w_to_hit  = (TIMEOUT_CYC > 0) && (to_q == TO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            es_ch_q <= '0;
            deb_q   <= '0;
            to_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            es_ch_q <= es_ch_d;
            deb_q   <= deb_d;
            to_q    <= to_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        es_ch_d = es_ch_q;
        deb_d   = deb_q;
        to_d    = to_q;
        sync1_d = bus.ch_btn;
        sync2_d = sync1_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        err_d   = 1'b0;

        // A context swap freezes the FSM and counters; the synchroniser
        // keeps sampling so the button level is current on resume.
        if (!bus.swap_SO) begin
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_sel_ok) begin
                            state_d = S_WAIT_PRESS;
                            es_ch_d = w_sel;
                            deb_d   = '0;
                            to_d    = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WAIT_PRESS, S_WAIT_RELEASE: begin
                    deb_d = w_target ? deb_q + DEB_W'(1) : '0;
                    if (TIMEOUT_CYC > 0) begin
                        to_d = to_q + TO_W'(1);
                    end
                    // A completed release beats a simultaneous timeout; a
                    // completed press does not, since no release happened.
                    if ((state_q == S_WAIT_RELEASE) && w_deb_hit) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (w_to_hit) begin
                        state_d = S_DONE;
                        tmo_d   = 1'b1;
                    end else if (w_deb_hit) begin
                        state_d = S_WAIT_RELEASE;
                        deb_d   = '0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.pausaPC = 1'b1;
        bus.busy    = 1'b0;
        case (state_q)
            // Stall in the same cycle the request is seen so the PC never
            // steps past an IN/OUT instruction.
            S_IDLE:         bus.pausaPC = !(w_req && w_sel_ok);
            S_WAIT_PRESS,
            S_WAIT_RELEASE: begin
                bus.pausaPC = 1'b0;
                bus.busy    = 1'b1;
            end
            default:        bus.pausaPC = 1'b1;
        endcase
        // Reset value is visible while rst_n is held low, even if the
        // instruction bus still presents a request.
        if (!rst_n) begin
            bus.pausaPC = 1'b1;
        end
    end

    assign bus.es_ch      = es_ch_q;
    assign bus.es_done    = done_q;
    assign bus.es_timeout = tmo_q;
    assign bus.es_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uc_es_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uc_es_handshake
//  Purpose  : Directed self-checking bench for uc_es_handshake. Instance 0 has
//             no timeout, instance 1 has TIMEOUT_CYC=20.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uc_es_handshake;
    localparam logic [31:0] NOP = 32'h2000_0000;  // opcode 8, never IN/OUT

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    uc_es_handshake_if #(.N_CH(4)) if0 ();
    uc_es_handshake_if #(.N_CH(4)) if1 ();

    uc_es_handshake #(.N_CH(4), .DEB_CYCLES(4), .TIMEOUT_CYC(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    uc_es_handshake #(.N_CH(4), .DEB_CYCLES(4), .TIMEOUT_CYC(20)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({if0.pausaPC, if0.busy, if0.es_ch, if0.es_done, if0.es_timeout, if0.es_err} !== 7'b1_0_00_000) begin
            n_fail++;
            $display("FAIL reset_dut0: got pausa/busy/ch/done/tmo/err=%b%b%b%b%b%b want 1 0 00 0 0 0",
                     if0.pausaPC, if0.busy, if0.es_ch, if0.es_done, if0.es_timeout, if0.es_err);
        end
        n_cmp++;
        if ({if1.pausaPC, if1.busy, if1.es_ch, if1.es_done, if1.es_timeout, if1.es_err} !== 7'b1_0_00_000) begin
            n_fail++;
            $display("FAIL reset_dut1: got pausa/busy/ch/done/tmo/err=%b%b%b%b%b%b want 1 0 00 0 0 0",
                     if1.pausaPC, if1.busy, if1.es_ch, if1.es_done, if1.es_timeout, if1.es_err);
        end
        n_cmp++;
        if ({if0.controle_in, if0.controle_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_decode_nop: got in/out=%b%b want 00", if0.controle_in, if0.controle_out);
        end
    endtask

    // IN on channel 0: press 10 cycles, release 10 cycles.
    task automatic test_in_ch0();
        logic eb;
        logic ed;
        step();
        if0.instr = 32'h0000_0000;
        #1;
        n_cmp++;
        if ({if0.controle_in, if0.controle_out, if0.pausaPC} !== 3'b100) begin
            n_fail++;
            $display("FAIL in_accept: got in/out/pausa=%b%b%b want 100",
                     if0.controle_in, if0.controle_out, if0.pausaPC);
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1)  if0.ch_btn[0] = 1'b1;
            if (i == 11) if0.ch_btn[0] = 1'b0;
            if (i == 18) if0.instr = NOP;
            #1;
            eb = (i <= 16);
            ed = (i == 17);
            n_cmp++;
            if ({if0.busy, if0.pausaPC, if0.es_done, if0.es_timeout} !== {eb, ~eb, ed, 1'b0}) begin
                n_fail++;
                $display("FAIL in_ch0 cyc %0d: got busy/pausa/done/tmo=%b%b%b%b want %b%b%b0",
                         i, if0.busy, if0.pausaPC, if0.es_done, if0.es_timeout, eb, ~eb, ed);
            end
        end
    endtask

    // OUT on channel 2 with two 2-cycle glitches, channel 0 held meanwhile.
    task automatic test_out_glitch();
        logic eb;
        logic ed;
        step();
        if0.instr = 32'h0040_0001;
        #1;
        n_cmp++;
        if ({if0.controle_in, if0.controle_out, if0.pausaPC} !== 3'b010) begin
            n_fail++;
            $display("FAIL out_accept: got in/out/pausa=%b%b%b want 010",
                     if0.controle_in, if0.controle_out, if0.pausaPC);
        end
        for (int i = 1; i <= 30; i++) begin
            step();
            case (i)
                1:  begin if0.ch_btn[2] = 1'b1; if0.ch_btn[0] = 1'b1; end
                3:  if0.ch_btn[2] = 1'b0;
                6:  if0.ch_btn[2] = 1'b1;
                8:  if0.ch_btn[2] = 1'b0;
                12: if0.ch_btn[2] = 1'b1;
                22: if0.ch_btn[2] = 1'b0;
                28: if0.ch_btn[0] = 1'b0;
                29: if0.instr = NOP;
                default: ;
            endcase
            #1;
            if (i == 1) begin
                n_cmp++;
                if (if0.es_ch !== 2'd2) begin
                    n_fail++;
                    $display("FAIL out_es_ch: got %0d want 2", if0.es_ch);
                end
            end
            eb = (i <= 27);
            ed = (i == 28);
            n_cmp++;
            if ({if0.busy, if0.pausaPC, if0.es_done} !== {eb, ~eb, ed}) begin
                n_fail++;
                $display("FAIL out_glitch cyc %0d: got busy/pausa/done=%b%b%b want %b%b%b",
                         i, if0.busy, if0.pausaPC, if0.es_done, eb, ~eb, ed);
            end
        end
    endtask

    // TIMEOUT_CYC=20, nobody presses.
    task automatic test_timeout();
        logic eb;
        logic et;
        step();
        if1.instr = 32'h0000_0000;
        for (int i = 1; i <= 23; i++) begin
            step();
            if (i == 22) if1.instr = NOP;
            #1;
            eb = (i <= 20);
            et = (i == 21);
            n_cmp++;
            if ({if1.busy, if1.pausaPC, if1.es_timeout, if1.es_done} !== {eb, ~eb, et, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got busy/pausa/tmo/done=%b%b%b%b want %b%b%b0",
                         i, if1.busy, if1.pausaPC, if1.es_timeout, if1.es_done, eb, ~eb, et);
            end
        end
    endtask

    // Requests on rs = 4, 5, 31 with N_CH=4 are rejected.
    task automatic test_bad_channel();
        logic [4:0] rs_tab [3];
        rs_tab[0] = 5'd4;
        rs_tab[1] = 5'd5;
        rs_tab[2] = 5'd31;
        for (int k = 0; k < 3; k++) begin
            step();
            if0.instr = {6'd0, rs_tab[k], 21'd0};
            #1;
            n_cmp++;
            if ({if0.pausaPC, if0.es_err} !== 2'b10) begin
                n_fail++;
                $display("FAIL err_req rs=%0d: got pausa/err=%b%b want 10", rs_tab[k], if0.pausaPC, if0.es_err);
            end
            step();
            if0.instr = NOP;
            #1;
            n_cmp++;
            if ({if0.es_err, if0.busy, if0.pausaPC} !== 3'b101) begin
                n_fail++;
                $display("FAIL err_pulse rs=%0d: got err/busy/pausa=%b%b%b want 101",
                         rs_tab[k], if0.es_err, if0.busy, if0.pausaPC);
            end
            step();
            #1;
            n_cmp++;
            if (if0.es_err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_one_cycle rs=%0d: got %b want 0", rs_tab[k], if0.es_err);
            end
        end
    endtask

    // Like test_in_ch0, with swap_SO held for 8 cycles during WAIT_RELEASE.
    task automatic test_swap();
        logic eb;
        logic ed;
        step();
        if0.instr = 32'h0000_0000;
        for (int i = 1; i <= 27; i++) begin
            step();
            if (i == 1)  if0.ch_btn[0] = 1'b1;
            if (i == 11) if0.ch_btn[0] = 1'b0;
            if (i == 14) if0.swap_SO   = 1'b1;
            if (i == 22) if0.swap_SO   = 1'b0;
            if (i == 26) if0.instr     = NOP;
            #1;
            eb = (i <= 24);
            ed = (i == 25);
            n_cmp++;
            if ({if0.busy, if0.pausaPC, if0.es_done} !== {eb, ~eb, ed}) begin
                n_fail++;
                $display("FAIL swap cyc %0d: got busy/pausa/done=%b%b%b want %b%b%b",
                         i, if0.busy, if0.pausaPC, if0.es_done, eb, ~eb, ed);
            end
        end
    endtask

    // Asynchronous reset during WAIT_PRESS on channel 1.
    task automatic test_reset_mid();
        step();
        if0.instr = 32'h0020_0000;
        step();
        if0.ch_btn[1] = 1'b1;
        #1;
        n_cmp++;
        if ({if0.busy, if0.es_ch} !== 3'b1_01) begin
            n_fail++;
            $display("FAIL rstmid_busy: got busy/ch=%b%0d want 1 1", if0.busy, if0.es_ch);
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if0.busy, if0.pausaPC, if0.es_ch} !== 4'b0_1_00) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy/pausa/ch=%b%b%0d want 0 1 0", if0.busy, if0.pausaPC, if0.es_ch);
        end
        if0.instr     = NOP;
        if0.ch_btn[1] = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            n_cmp++;
            if ({if0.busy, if0.pausaPC, if0.es_done, if0.es_timeout, if0.es_err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL rstmid_after cyc %0d: got busy/pausa/done/tmo/err=%b%b%b%b%b want 01000",
                         i, if0.busy, if0.pausaPC, if0.es_done, if0.es_timeout, if0.es_err);
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        if0.instr     = NOP;
        if0.swap_SO   = 1'b0;
        if0.ch_btn    = '0;
        if1.instr     = NOP;
        if1.swap_SO   = 1'b0;
        if1.ch_btn    = '0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        test_in_ch0();
        test_out_glitch();
        test_timeout();
        test_bad_channel();
        test_swap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
